// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the four-bank memory arbiter.
package mem_arb_pkg;

    localparam int NUM_BANKS   = 4;
    localparam int BANK_W      = 2;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Winner selection: round-robin from ptr when MEM_ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with the lowest index winning (ptr ignored).
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the ring starting at ptr; the first requester seen wins.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no latch is inferred.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto four synchronous memory banks sharing one
// address/data bus. MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [BANK_W*NUM_REQ-1:0] req_bank,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         memory_addr,
    output logic [DATA_W-1:0]         memory_data,
    output logic [NUM_BANKS-1:0]      mem_w_en,
    input  logic [DATA_W-1:0]         mem_0_out,
    input  logic [DATA_W-1:0]         mem_1_out,
    input  logic [DATA_W-1:0]         mem_2_out,
    input  logic [DATA_W-1:0]         mem_3_out
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t               state;
    state_t               next_state;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     ptr;
    logic [NUM_REQ-1:0]   grant_q;
    logic [BANK_W-1:0]    bank_q;
    logic                 we_q;
    logic [DATA_W-1:0]    bank_rdata;
    logic                 accept;

    assign accept = (state == IDLE) && (|req);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    // Next search starts one past the winner, wrapping at NUM_REQ-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // Request fields are captured only when a winner is accepted in IDLE, so a
    // requester changing them mid-access cannot disturb the access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state       <= IDLE;
            grant_q     <= '0;
            bank_q      <= '0;
            we_q        <= 1'b0;
            memory_addr <= '0;
            memory_data <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                grant_q     <= pick_grant;
                we_q        <= req_we[pick_idx];
                bank_q      <= req_bank[BANK_W*pick_idx +: BANK_W];
                memory_addr <= req_addr[ADDR_W*pick_idx +: ADDR_W];
                if (req_we[pick_idx]) begin
                    memory_data <= req_wdata[DATA_W*pick_idx +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        case (bank_q)
            2'd0:    bank_rdata = mem_0_out;
            2'd1:    bank_rdata = mem_1_out;
            2'd2:    bank_rdata = mem_2_out;
            default: bank_rdata = mem_3_out;
        endcase
    end

    always_comb begin
        next_state = state;
        ack        = '0;
        mem_w_en   = '0;
        rdata      = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    mem_w_en[bank_q] = 1'b1;
                    ack              = grant_q;
                    next_state       = IDLE;
                end else begin
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                ack        = grant_q;
                rdata      = bank_rdata;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // A reset in ISSUE or RD_WAIT aborts the access in its own cycle.
        if (rst) begin
            ack      = '0;
            mem_w_en = '0;
            rdata    = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural four-bank synchronous memory.
// Arbitration expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 50;

    typedef struct {
        int idx;
        bit we;
        int bank;
        int addr;
        int data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [2*NUM_REQ-1:0]      req_bank;
    logic [ADDR_W*NUM_REQ-1:0] req_addr;
    logic [DATA_W*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         memory_addr;
    logic [DATA_W-1:0]         memory_data;
    logic [3:0]                mem_w_en;
    logic [DATA_W-1:0]         mem_out [4];

    logic [DATA_W-1:0]         bank_mem [4][1 << ADDR_W];

    exp_t sb [$];
    int   ack_cycles [$];
    int   n_checks     = 0;
    int   n_errors     = 0;
    int   ack_cnt      = 0;
    int   last_ack_cyc = 0;
    int   cyc          = 0;
    exp_t mon_e;

    mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_we      (req_we),
        .req_bank    (req_bank),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .ack         (ack),
        .rdata       (rdata),
        .memory_addr (memory_addr),
        .memory_data (memory_data),
        .mem_w_en    (mem_w_en),
        .mem_0_out   (mem_out[0]),
        .mem_1_out   (mem_out[1]),
        .mem_2_out   (mem_out[2]),
        .mem_3_out   (mem_out[3])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_w_en[b]) bank_mem[b][memory_addr] <= memory_data;
            mem_out[b] <= bank_mem[b][memory_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (mem_w_en != 4'b0000) begin
            if (sb.size() == 0 || ack == '0) begin
                check("wen_without_ack", {28'b0, mem_w_en}, 32'd0);
            end else begin
                check("wen_bank", {28'b0, mem_w_en}, 32'd1 << sb[0].bank);
                check("wen_addr", {22'b0, memory_addr}, sb[0].addr);
                check("wen_data", {24'b0, memory_data}, sb[0].data);
            end
        end
        if (ack != '0) begin
            ack_cnt++;
            last_ack_cyc = cyc;
            ack_cycles.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_ack", {28'b0, ack}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_onehot", {31'b0, $onehot(ack)}, 32'd1);
                check("ack_idx", {28'b0, ack}, 32'd1 << mon_e.idx);
                if (mon_e.we) begin
                    check("wr_wen_seen", {31'b0, (mem_w_en != 4'b0000)}, 32'd1);
                end else begin
                    check("rd_wen_idle", {28'b0, mem_w_en}, 32'd0);
                    check("rd_data", {24'b0, rdata}, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int i, input bit we, input int bank, input int addr, input int data);
        req_we[i]                  = we;
        req_bank[2*i +: 2]         = bank[1:0];
        req_addr[ADDR_W*i +: ADDR_W] = addr[ADDR_W-1:0];
        req_wdata[DATA_W*i +: DATA_W] = data[DATA_W-1:0];
    endtask

    task automatic push_exp(input int i, input bit we, input int bank, input int addr, input int data);
        exp_t e;
        e.idx  = i;
        e.we   = we;
        e.bank = bank;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_acks(input int n, input string tag);
        int target;
        int k;
        target = ack_cnt + n;
        k = 0;
        while (ack_cnt < target && k < TIMEOUT) begin
            tick();
            k++;
        end
        if (ack_cnt < target) check({tag, "_timeout"}, ack_cnt, target);
    endtask

    // Latency counts clock edges from the request being driven to the edge that captures ack.
    task automatic do_access(input int i, input bit we, input int bank, input int addr,
                             input int data, output int lat);
        int start;
        push_exp(i, we, bank, addr, data);
        set_fields(i, we, bank, addr, we ? data : 0);
        start  = cyc;
        req[i] = 1'b1;
        wait_acks(1, "access");
        req[i] = 1'b0;
        lat    = last_ack_cyc + 1 - start;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int s;
        int n_arb;
        int order [5];

        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < (1 << ADDR_W); a++) bank_mem[b][a] = '0;
        end
        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_bank  = '0;
        req_addr  = '0;
        req_wdata = '0;
        tick();
        tick();
        check("rst_ack", {28'b0, ack}, 32'd0);
        check("rst_wen", {28'b0, mem_w_en}, 32'd0);
        check("rst_rdata", {24'b0, rdata}, 32'd0);
        check("rst_addr", {22'b0, memory_addr}, 32'd0);
        check("rst_data", {24'b0, memory_data}, 32'd0);
        rst = 1'b0;
        tick();

        // Single write then read-back on bank 2.
        do_access(0, 1'b1, 2, 'h005, 'hA5, lat);
        check("wr_latency", lat, 2);
        do_access(0, 1'b0, 2, 'h005, 'hA5, lat);
        check("rd_latency", lat, 3);

        // Same address in every bank: each bank must keep its own value.
        for (int b = 0; b < 4; b++) do_access(b, 1'b1, b, 'h3FF, 'h11 * (b + 1), lat);
        for (int b = 0; b < 4; b++) do_access(b, 1'b0, b, 'h3FF, 'h11 * (b + 1), lat);
        do_access(1, 1'b0, 2, 'h005, 'hA5, lat);

        // All requesters hold req high with writes.
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        n_arb = 5;
        order = '{0, 1, 2, 3, 0};
`else
        n_arb = 3;
        order = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < NUM_REQ; i++) set_fields(i, 1'b1, i, 'h100 + i, 'hC0 + i);
        for (int j = 0; j < n_arb; j++) begin
            push_exp(order[j], 1'b1, order[j], 'h100 + order[j], 'hC0 + order[j]);
        end
        s   = ack_cycles.size();
        req = 4'hF;
        wait_acks(n_arb, "arb");
        req = '0;
        for (int j = 1; j < n_arb; j++) begin
            if (ack_cycles.size() > s + j) check("ack_spacing", ack_cycles[s+j] - ack_cycles[s+j-1], 2);
        end
        tick();
        tick();

        // Reset in the RD_WAIT cycle of a read by requester 1.
        set_fields(1, 1'b0, 2, 'h005, 0);
        req[1] = 1'b1;
        tick();
        tick();
        rst    = 1'b1;
        req[1] = 1'b0;
        #1;
        check("abort_ack", {28'b0, ack}, 32'd0);
        check("abort_rdata", {24'b0, rdata}, 32'd0);
        tick();
        check("abort_wen", {28'b0, mem_w_en}, 32'd0);
        check("abort_addr", {22'b0, memory_addr}, 32'd0);
        check("abort_data", {24'b0, memory_data}, 32'd0);
        rst = 1'b0;
        tick();

        // After reset, requester 0 wins ahead of requester 2.
        push_exp(0, 1'b1, 1, 'h0AA, 'h5A);
        push_exp(2, 1'b1, 3, 'h155, 'h3C);
        set_fields(0, 1'b1, 1, 'h0AA, 'h5A);
        set_fields(2, 1'b1, 3, 'h155, 'h3C);
        req[0] = 1'b1;
        req[2] = 1'b1;
        wait_acks(1, "post_rst_first");
        req[0] = 1'b0;
        wait_acks(1, "post_rst_second");
        req[2] = 1'b0;
        do_access(3, 1'b0, 1, 'h0AA, 'h5A, lat);
        do_access(3, 1'b0, 3, 'h155, 'h3C, lat);

        tick();
        tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
